// File: rtl/seq_calculator_if.sv
// Operand/result handshake bundle for seq_calculator.
// The master side presents operands and consumes results; the slave side is the calculator.
interface seq_calculator_if #(
  parameter int BIT_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [BIT_WIDTH-1:0] a;
  logic [BIT_WIDTH-1:0] b;
  logic [2:0]           op;
  logic                 out_valid;
  logic                 out_ready;
  logic [BIT_WIDTH-1:0] result;
  logic [2:0]           status;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, status
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, status
  );
endinterface

// File: rtl/seq_calculator.sv
// Multi-cycle handshaked calculator: ADD, SUB, shift-add MUL, accumulate and clear.
// One operation in flight; result/status are registered and held until popped.
module seq_calculator #(
  parameter int BIT_WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  seq_calculator_if.slave   bus
);

  localparam int W     = BIT_WIDTH;
  localparam int CNT_W = (BIT_WIDTH > 2) ? $clog2(BIT_WIDTH) : 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_ACC = 3'd3;
  localparam logic [2:0] OP_CLR = 3'd4;

  localparam logic [2:0] ST_STANDBY  = 3'd0;
  localparam logic [2:0] ST_VALID    = 3'd1;
  localparam logic [2:0] ST_OVERFLOW = 3'd2;
  localparam logic [2:0] ST_NEGATIVE = 3'd3;
  localparam logic [2:0] ST_ERROR    = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       result_q, result_d;
  logic [2:0]         status_q, status_d;
  logic [W-1:0]       acc_q, acc_d;
  logic [2*W-1:0]     prod_q, prod_d;
  logic [W-1:0]       mcand_q, mcand_d;
  logic [W-1:0]       mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [W:0]         add_sum;
  logic [W:0]         acc_sum;
  logic [W:0]         mul_hi;
  logic [2*W-1:0]     prod_next;

  // Arithmetic helpers shared by the next-state logic
  always_comb begin
    add_sum   = {1'b0, bus.a} + {1'b0, bus.b};
    acc_sum   = {1'b0, acc_q} + {1'b0, bus.a};
    // One shift-add step: add the multiplicand into the upper half when the
    // current multiplier LSB is set, then shift the whole product right.
    mul_hi    = {1'b0, prod_q[2*W-1:W]} + (mplier_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
    prod_next = {mul_hi, prod_q[W-1:1]};
  end

  // Next-state and datapath update; every register holds unless a branch changes it
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    status_d = status_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d = S_DONE;
          case (bus.op)
            OP_ADD: begin
              result_d = add_sum[W-1:0];
              status_d = add_sum[W] ? ST_OVERFLOW : ST_VALID;
            end
            OP_SUB: begin
              result_d = bus.a - bus.b;
              status_d = (bus.a < bus.b) ? ST_NEGATIVE : ST_VALID;
            end
            OP_MUL: begin
              state_d  = S_MUL;
              mcand_d  = bus.a;
              mplier_d = bus.b;
              prod_d   = '0;
              cnt_d    = '0;
            end
            OP_ACC: begin
              acc_d    = acc_sum[W-1:0];
              result_d = acc_sum[W-1:0];
              status_d = acc_sum[W] ? ST_OVERFLOW : ST_VALID;
            end
            OP_CLR: begin
              acc_d    = '0;
              result_d = '0;
              status_d = ST_VALID;
            end
            default: begin
              result_d = '0;
              status_d = ST_ERROR;
            end
          endcase
        end
      end

      S_MUL: begin
        prod_d   = prod_next;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        // The last multiplier bit is consumed this cycle, so publish the
        // finished product straight from the step logic.
        if (cnt_q == CNT_W'(W - 1)) begin
          state_d  = S_DONE;
          result_d = prod_next[W-1:0];
          status_d = (|prod_next[2*W-1:W]) ? ST_OVERFLOW : ST_VALID;
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      status_q <= ST_STANDBY;
      acc_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      status_q <= status_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.status    = status_q;

endmodule

// File: tb/tb_seq_calculator.sv
// Randomised and directed bench for seq_calculator against an arithmetic reference model.
module tb_seq_calculator;

  localparam int W = 8;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  longint acc_m;

  seq_calculator_if #(.BIT_WIDTH(W)) bus ();

  seq_calculator #(.BIT_WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison helper: every check in the bench goes through here
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model straight from the arithmetic rules
  function automatic void model(input int op, input longint a, input longint b,
                                inout longint acc, output longint res, output int st);
    longint m;
    longint s;
    m = longint'(1) << W;
    case (op)
      0: begin s = a + b; res = s % m; st = (s >= m) ? 2 : 1; end
      1: begin res = (a - b + m) % m; st = (a < b) ? 3 : 1; end
      2: begin s = a * b; res = s % m; st = (s >= m) ? 2 : 1; end
      3: begin s = acc + a; acc = s % m; res = acc; st = (s >= m) ? 2 : 1; end
      4: begin acc = 0; res = 0; st = 1; end
      default: begin res = 0; st = 4; end
    endcase
  endfunction

  // One complete transaction: present, wait for result, optionally stall, pop
  task automatic run_op(input int op, input int a, input int b,
                        input int stall, input bit early, input bit junk);
    longint er;
    int     es;
    int     lat;
    int     exp_lat;
    model(op, longint'(a), longint'(b), acc_m, er, es);
    exp_lat = (op == 2) ? W + 1 : 1;

    @(negedge clk);
    check("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.op       = 3'(op);
    bus.a        = W'(a);
    bus.b        = W'(b);
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs after capture; optionally keep a MUL request asserted
    bus.in_valid = junk;
    bus.op       = 3'd2;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    if (early) bus.out_ready = 1'b1;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("result", 64'(bus.result), 64'(er));
    check("status", 64'(bus.status), 64'(es));

    if (!early) begin
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        check("hold_ready", 64'(bus.in_ready), 64'd0);
        check("hold_result", 64'(bus.result), 64'(er));
        check("hold_status", 64'(bus.status), 64'(es));
      end
      bus.out_ready = 1'b1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("pop_valid", 64'(bus.out_valid), 64'd0);
    check("pop_ready", 64'(bus.in_ready), 64'd1);
    check("pop_result", 64'(bus.result), 64'(er));
    check("pop_status", 64'(bus.status), 64'(es));
    bus.out_ready = 1'b0;
  endtask

  // Watchdog so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    acc_m         = 0;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = '0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_status", 64'(bus.status), 64'd0);
    reset_n = 1'b1;

    // Directed arithmetic cases
    run_op(0, 200, 100, 0, 0, 0);
    run_op(0, 100, 27, 1, 0, 0);
    run_op(1, 5, 9, 0, 0, 0);
    run_op(1, 9, 5, 0, 1, 0);
    run_op(1, 0, 0, 0, 0, 0);
    run_op(2, 15, 17, 0, 0, 0);
    run_op(2, 16, 16, 0, 1, 0);
    run_op(2, 255, 0, 0, 0, 1);
    run_op(3, 250, 0, 0, 0, 0);
    run_op(3, 10, 0, 0, 0, 0);
    run_op(4, 0, 0, 0, 0, 0);
    run_op(3, 3, 0, 0, 0, 0);

    // Backpressure with a MUL request held during the stall
    run_op(0, 1, 2, 5, 0, 1);
    repeat (3) begin
      @(negedge clk);
      check("no_capture", 64'(bus.out_valid), 64'd0);
    end

    // Reset in the 4th MUL cycle
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 3'd2;
    bus.a        = W'(15);
    bus.b        = W'(17);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_result", 64'(bus.result), 64'd0);
    check("arst_status", 64'(bus.status), 64'd0);
    acc_m = 0;
    @(negedge clk);
    reset_n = 1'b1;
    run_op(3, 7, 0, 0, 0, 0);
    run_op(6, 33, 44, 0, 0, 0);
    run_op(3, 1, 0, 0, 0, 0);

    // Randomised traffic
    for (int n = 0; n < 150; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op > 7) op = 2;
      run_op(op, int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_calculator.md
# seq_calculator

Multi-cycle, handshaked calculator. It generalises the single-cycle ADD/SUB calculator path to:
- any operand width;
- five operations: add, subtract, shift-add multiply, accumulate, clear accumulator;
- valid/ready flow control on both input and output.

It sits between an operand source and a result consumer. It can stall either side and holds one operation in flight at a time.

## Interface
- BIT_WIDTH, 8: operand, result and accumulator width in bits (≥ 2).

- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and op presented.
- in_ready  output  1  block can accept an operation.
- a  input  BIT_WIDTH  operand A (unsigned).
- b  input  BIT_WIDTH  operand B (unsigned).
- op  input  3  operation code:
  - 0 ADD, 1 SUB, 2 MUL, 3 ACC, 4 CLR;
  - 5–7 illegal.
- out_valid  output  1  result and status valid.
- out_ready  input  1  consumer accepts result.
- result  output  BIT_WIDTH  registered result.
- status  output  3  registered status: 0 STANDBY, 1 VALID, 2 OVERFLOW, 3 NEGATIVE, 4 ERROR.

## Operation
- Clocking and reset: one clock domain; reset is asynchronous and active-low.
- States:
  - IDLE: in_ready = 1.
  - MUL: in_ready = 0.
  - DONE: out_valid = 1, in_ready = 0.
- Accept: in_valid && in_ready at a rising edge. a, b and op are captured into internal registers; inputs may change afterwards.
- Transitions:
  - IDLE→DONE on accepting ADD, SUB, ACC, CLR or an illegal op.
  - IDLE→MUL on accepting MUL.
  - MUL→DONE after BIT_WIDTH iterations.
  - DONE→IDLE on out_valid && out_ready.
- Arithmetic (W = BIT_WIDTH, all values unsigned, results mod 2^W):
  - ADD: result = a+b. Status OVERFLOW if the carry out of bit W-1 is 1, else VALID.
  - SUB: result = a-b. Status NEGATIVE if a < b, else VALID.
  - MUL: shift-add over a 2W-bit product register, one multiplier bit per cycle, LSB first, with a log2-width iteration counter. result = product[W-1:0]. Status OVERFLOW if product[2W-1:W] ≠ 0, else VALID.
  - ACC: acc ← acc + a (b ignored), and result = new acc. Status OVERFLOW on carry out, else VALID. acc wraps.
  - CLR: acc ← 0, result = 0, status VALID.
  - Illegal op (5–7): result = 0, status ERROR; acc unchanged.
- acc is an internal W-bit register. It resets to 0 and changes only on ACC and CLR.
- Output hold:
  - result and status update only on the transition into DONE.
  - They hold their values while out_valid = 0 and keep the last values after the pop.
  - status reads STANDBY only after reset, before the first operation completes.
- While in MUL or DONE, in_valid is ignored: no capture and no side effects.

## Timing
- Reset values:
  - in_ready = 1, out_valid = 0, result = 0, status = STANDBY (0);
  - acc = 0, state IDLE, counter 0, product 0.
- Latency, with accept at edge T:
  - ADD/SUB/ACC/CLR/illegal: out_valid = 1 from edge T+1.
  - MUL: out_valid = 1 from edge T+1+BIT_WIDTH.
- Pop at edge P (out_valid && out_ready): out_valid = 0 and in_ready = 1 from P.
- The earliest next accept is P+1, so peak throughput is one operation per 2 cycles.
- out_ready already high on entering DONE: out_valid is still high for exactly one cycle.
- out_ready low: out_valid, result and status stay stable indefinitely.
- out_ready is don't-care outside DONE.
- Reset asserted in any state: all outputs and internal state go to their reset values immediately (asynchronously). An in-flight operation is discarded and acc is cleared.
- Reset deassertion is synchronised externally; there is no requirement inside the block.

## Test plan
- ADD, W=8, a=200, b=100, accept at T → out_valid at T+1, result=44, status OVERFLOW. Then a=100, b=27 → result 127, VALID.
- SUB, a=5, b=9 → result 252, NEGATIVE. Then a=9, b=5 → result 4, VALID. Then a=b=0 → result 0, VALID.
- MUL, a=15, b=17 → out_valid exactly at T+9, result 255, VALID. Then a=16, b=16 → result 0, OVERFLOW. Then a=255, b=0 → result 0, VALID.
- Accumulator sequence:
  - ACC 250 → 250, VALID.
  - ACC 10 → 4, OVERFLOW.
  - CLR → 0, VALID.
  - ACC 3 → 3, VALID.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after ADD 1+2. Required: out_valid=1, result=3 stable, in_ready=0.
  - A MUL presented with in_valid=1 during the stall is not captured.
  - Pop, then in_ready=1 on the next cycle.
- Reset and illegal op:
  - Assert reset_n=0 at the 4th MUL cycle. Required: immediately in_ready=1, out_valid=0, result=0, status STANDBY, and a later ACC 7 returns 7.
  - op=6 → result 0, status ERROR, acc unchanged.
